// File: rtl/ro_puf_pkg.sv
// Shared defaults and FSM state encoding for the ring-oscillator PUF response path.
package ro_puf_pkg;
  localparam int CNT_W_DEF     = 16;
  localparam int RESP_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_HOLD    = 2'd3
  } state_e;
endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a registered previous-value stage for rise/fall detection.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign q    = s2;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
endmodule

// File: rtl/ro_response_capture.sv
// Counts two ring-oscillator edges per enable window and packs the A>B comparison
// results into a RESP_BITS response word with a valid/ack handshake.
module ro_response_capture
  import ro_puf_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RESP_BITS = RESP_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_in,
  input  logic                 rs_in,
  input  logic                 ro_a,
  input  logic                 ro_b,
  input  logic                 resp_ack,
  output logic [RESP_BITS-1:0] resp,
  output logic                 resp_valid,
  output logic                 resp_tie,
  output logic                 overrun,
  output logic                 busy
);
  localparam int NSIG  = 4;
  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

  // lane order: 3 en, 2 rs, 1 ro_a, 0 ro_b
  logic [NSIG-1:0] sig_in, sig_s, sig_rise, sig_fall;
  assign sig_in = {en_in, rs_in, ro_a, ro_b};

  for (genvar g = 0; g < NSIG; g++) begin : g_sync
    sync_edge u_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (sig_in[g]),
      .q    (sig_s[g]),
      .rise (sig_rise[g]),
      .fall (sig_fall[g])
    );
  end

  logic en_s, rs_s, a_s, b_s;
  logic en_rise, en_fall, rs_rise, a_rise, b_rise;
  assign en_s    = sig_s[3];
  assign rs_s    = sig_s[2];
  assign a_s     = sig_s[1];
  assign b_s     = sig_s[0];
  assign en_rise = sig_rise[3];
  assign en_fall = sig_fall[3];
  assign rs_rise = sig_rise[2];
  assign a_rise  = sig_rise[1];
  assign b_rise  = sig_rise[0];

  logic unused_sync;
  assign unused_sync = ^{en_s, a_s, b_s, sig_fall[2:0]};

  state_e state, state_n;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [IDX_W-1:0] bit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // rs_s takes priority over any enable edge seen in the same cycle
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:    if (en_rise && !rs_s) state_n = ST_COUNT;
      ST_COUNT:   if (rs_rise) state_n = ST_IDLE;
                  else if (en_fall && !rs_s) state_n = ST_COMPARE;
      ST_COMPARE: state_n = ST_HOLD;
      ST_HOLD:    if (rs_rise) state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_COUNT) || (state == ST_COMPARE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (rs_rise) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (state == ST_COUNT) begin
      if (a_rise && cnt_a != '1) cnt_a <= cnt_a + CNT_W'(1);
      if (b_rise && cnt_b != '1) cnt_b <= cnt_b + CNT_W'(1);
    end
  end

  // An ack in the COMPARE cycle frees the word first, so the new bit starts the next one.
  logic                 hs, cmp_bit, cmp_tie;
  logic [RESP_BITS-1:0] resp_base;
  logic                 tie_base;
  assign hs        = resp_valid & resp_ack;
  assign cmp_bit   = cnt_a > cnt_b;
  assign cmp_tie   = cnt_a == cnt_b;
  assign resp_base = hs ? '0 : resp;
  assign tie_base  = hs ? 1'b0 : resp_tie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp       <= '0;
      resp_valid <= 1'b0;
      resp_tie   <= 1'b0;
      overrun    <= 1'b0;
      bit_idx    <= '0;
    end else begin
      if (hs) begin
        resp       <= '0;
        resp_valid <= 1'b0;
        resp_tie   <= 1'b0;
      end
      if (state == ST_COMPARE) begin
        if (resp_valid && !resp_ack) begin
          overrun <= 1'b1;
        end else begin
          resp     <= {resp_base[RESP_BITS-2:0], cmp_bit};
          resp_tie <= tie_base | cmp_tie;
          if (bit_idx == LAST_IDX) begin
            resp_valid <= 1'b1;
            bit_idx    <= '0;
          end else begin
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ro_response_capture.sv
// Directed bench: table of comparison windows plus hand-written handshake/abort/reset sequences.
module tb_ro_response_capture;
  logic clk = 1'b0;
  logic rst, en_in, rs_in, ro_a, ro_b, resp_ack;
  logic [7:0] resp, resp4;
  logic resp_valid, resp_tie, overrun, busy;
  logic resp_valid4, resp_tie4, overrun4, busy4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ro_response_capture #(.CNT_W(16), .RESP_BITS(8)) dut (
    .clk(clk), .rst(rst), .en_in(en_in), .rs_in(rs_in), .ro_a(ro_a), .ro_b(ro_b),
    .resp_ack(resp_ack), .resp(resp), .resp_valid(resp_valid), .resp_tie(resp_tie),
    .overrun(overrun), .busy(busy)
  );

  ro_response_capture #(.CNT_W(4), .RESP_BITS(8)) dut4 (
    .clk(clk), .rst(rst), .en_in(en_in), .rs_in(rs_in), .ro_a(ro_a), .ro_b(ro_b),
    .resp_ack(resp_ack), .resp(resp4), .resp_valid(resp_valid4), .resp_tie(resp_tie4),
    .overrun(overrun4), .busy(busy4)
  );

  typedef struct {
    int   na;
    int   nb;
    logic exp_bit;
    logic exp_tie;
  } win_t;

  win_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulses(input int na, input int nb);
    int n;
    n = (na > nb) ? na : nb;
    for (int i = 0; i < n; i++) begin
      ro_a = (i < na);
      ro_b = (i < nb);
      repeat (3) tick();
      ro_a = 1'b0;
      ro_b = 1'b0;
      repeat (3) tick();
    end
    repeat (4) tick();
  endtask

  // Runs one enable window; lat = first cycle after en fall with resp_valid seen high.
  task automatic window(input int na, input int nb, input bit ack_cmp, output int lat);
    en_in = 1'b1;
    repeat (6) tick();
    pulses(na, nb);
    en_in = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ack_cmp) resp_ack = (k == 3);
      if (lat == 0 && resp_valid) lat = k;
    end
    resp_ack = 1'b0;
  endtask

  task automatic rs_pulse();
    rs_in = 1'b1;
    repeat (6) tick();
    rs_in = 1'b0;
    repeat (6) tick();
  endtask

  task automatic ack_pulse();
    resp_ack = 1'b1;
    tick();
    resp_ack = 1'b0;
    tick();
  endtask

  initial begin
    int   lat;
    logic [7:0] exp_resp;

    tbl[0]  = '{100, 90, 1'b1, 1'b0};
    tbl[1]  = '{5,   10, 1'b0, 1'b0};
    tbl[2]  = '{12,  3,  1'b1, 1'b0};
    tbl[3]  = '{8,   7,  1'b1, 1'b0};
    tbl[4]  = '{4,   9,  1'b0, 1'b0};
    tbl[5]  = '{3,   7,  1'b0, 1'b0};
    tbl[6]  = '{9,   2,  1'b1, 1'b0};
    tbl[7]  = '{2,   8,  1'b0, 1'b0};
    tbl[8]  = '{7,   3,  1'b1, 1'b0};
    tbl[9]  = '{3,   7,  1'b0, 1'b0};
    tbl[10] = '{50,  50, 1'b0, 1'b1};

    rst = 1'b1; en_in = 1'b0; rs_in = 1'b0; ro_a = 1'b0; ro_b = 1'b0; resp_ack = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", {resp, resp_valid, resp_tie, overrun, busy}, 32'h0);
    chk("reset_bit_idx", 32'(dut.bit_idx), 32'd0);
    rst = 1'b0;
    repeat (3) tick();

    // word 1: 8'hB2
    exp_resp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      window(tbl[i].na, tbl[i].nb, 1'b0, lat);
      exp_resp = {exp_resp[6:0], tbl[i].exp_bit};
      chk($sformatf("w1_bit%0d", i), 32'(resp[0]), 32'(tbl[i].exp_bit));
      chk($sformatf("w1_resp%0d", i), 32'(resp), 32'(exp_resp));
      chk($sformatf("w1_tie%0d", i), 32'(resp_tie), 32'(tbl[i].exp_tie));
      if (i < 7) chk($sformatf("w1_novalid%0d", i), 32'(resp_valid), 32'd0);
      else       chk("w1_latency", 32'(lat), 32'd4);
      rs_pulse();
    end
    repeat (10) tick();
    chk("w1_held_valid", 32'(resp_valid), 32'd1);
    chk("w1_held_resp", 32'(resp), 32'hB2);
    ack_pulse();
    chk("w1_ack_valid", 32'(resp_valid), 32'd0);
    chk("w1_ack_resp", 32'(resp), 32'd0);
    chk("w1_overrun", 32'(overrun), 32'd0);

    // word 2: tie in window 3, ack while idle ignored
    exp_resp = 8'h00;
    for (int i = 8; i < 11; i++) begin
      window(tbl[i].na, tbl[i].nb, 1'b0, lat);
      exp_resp = {exp_resp[6:0], tbl[i].exp_bit};
      chk($sformatf("w2_resp%0d", i - 8), 32'(resp), 32'(exp_resp));
      chk($sformatf("w2_tie%0d", i - 8), 32'(resp_tie), 32'(tbl[i].exp_tie));
      rs_pulse();
      if (i == 8) begin
        ack_pulse();
        chk("ack_no_valid_resp", 32'(resp), 32'h01);
        chk("ack_no_valid_idx", 32'(dut.bit_idx), 32'd1);
      end
    end

    // saturation on the 4-bit instance; 16-bit instance sees 20 > 16
    window(20, 16, 1'b0, lat);
    chk("sat_cnt_a", 32'(dut4.cnt_a), 32'd15);
    chk("sat_cnt_b", 32'(dut4.cnt_b), 32'd15);
    chk("sat_resp4", 32'(resp4), 32'h08);
    chk("sat_tie4", 32'(resp_tie4), 32'd1);
    chk("wide_resp", 32'(resp), 32'h09);
    chk("tie_sticky", 32'(resp_tie), 32'd1);
    rs_pulse();

    // async reset mid-window
    en_in = 1'b1;
    repeat (6) tick();
    pulses(5, 5);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {resp, resp_valid, resp_tie, overrun, busy}, 32'h0);
    en_in = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_after_outputs", {resp, resp_valid, resp_tie, overrun, busy}, 32'h0);

    // rs abort mid-window, then one full window
    en_in = 1'b1;
    repeat (6) tick();
    pulses(3, 3);
    rs_in = 1'b1;
    repeat (6) tick();
    rs_in = 1'b0;
    repeat (4) tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cnt_a", 32'(dut.cnt_a), 32'd0);
    en_in = 1'b0;
    repeat (8) tick();
    chk("abort_no_bit", 32'(dut.bit_idx), 32'd0);
    window(10, 5, 1'b0, lat);
    chk("after_abort_resp", 32'(resp), 32'h01);
    chk("after_abort_idx", 32'(dut.bit_idx), 32'd1);
    rs_pulse();

    // fill the word, then overrun, then ack coinciding with COMPARE
    for (int i = 0; i < 7; i++) begin
      window(6, 2, 1'b0, lat);
      rs_pulse();
    end
    chk("w3_valid", 32'(resp_valid), 32'd1);
    chk("w3_resp", 32'(resp), 32'hFF);
    window(2, 6, 1'b0, lat);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("overrun_resp", 32'(resp), 32'hFF);
    chk("overrun_valid", 32'(resp_valid), 32'd1);
    rs_pulse();
    window(9, 1, 1'b1, lat);
    chk("ack_cmp_resp", 32'(resp), 32'h01);
    chk("ack_cmp_valid", 32'(resp_valid), 32'd0);
    chk("ack_cmp_idx", 32'(dut.bit_idx), 32'd1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    rs_pulse();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
